// File: rtl/port_drain.sv
// ============================================================================
// Module   : port_drain
// Purpose  : Round-robin drain of four output-port FIFOs onto a single
//            valid/ready stream.
//            Each word is tagged with its source port. Per-port and total
//            delivered-word counters can be read back through a small
//            request/response interface.
// Revision : 1.0 - initial release
//
// Ports
//   clk          in   1  clock, all state on rising edge
//   rst_n        in   1  asynchronous active-low reset, released synchronously
//   empty        in   4  per-port FIFO empty flags (bit n = port n)
//   pop          out  4  one-hot FIFO pop (at most one bit high)
//   data_p0..p3  in  12  FIFO read data, valid the cycle after pop
//   enable       in   1  permits starting new reads
//   out_data     out 14  {port[1:0], word[11:0]}
//   out_valid    out  1  downstream valid
//   out_ready    in   1  downstream ready
//   req          in   1  counter read request
//   idx          in   3  counter index (0..3 per port, 4 total)
//   count_out    out  5  counter read data
//   count_valid  out  1  counter read response valid
// ============================================================================
`default_nettype none

module port_drain (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  empty,
    output logic [3:0]  pop,
    input  logic [11:0] data_p0,
    input  logic [11:0] data_p1,
    input  logic [11:0] data_p2,
    input  logic [11:0] data_p3,
    input  logic        enable,
    output logic [13:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        req,
    input  logic [2:0]  idx,
    output logic [4:0]  count_out,
    output logic        count_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [1:0]  sel;
    logic [1:0]  last_port;
    logic [4:0]  cnt [5];

    logic        rr_found;
    logic [1:0]  rr_port;
    logic [1:0]  cand;
    logic [11:0] rd_data;
    logic [4:0]  cnt_rd;
    logic        start;
    logic        capture;
    logic        complete;

    // Round-robin pick: scan last_port+1 .. last_port+4 (mod 4) and take the
    // first non-empty port. last_port itself is therefore checked last.
    always_comb begin
        rr_found = 1'b0;
        rr_port  = last_port;
        cand     = last_port;
        for (int i = 1; i <= 4; i++) begin
            cand = last_port + 2'(i);
            if (!rr_found && !empty[cand]) begin
                rr_found = 1'b1;
                rr_port  = cand;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    rd_data = data_p0;
            2'd1:    rd_data = data_p1;
            2'd2:    rd_data = data_p2;
            default: rd_data = data_p3;
        endcase
    end

    always_comb begin
        case (idx)
            3'd0:    cnt_rd = cnt[0];
            3'd1:    cnt_rd = cnt[1];
            3'd2:    cnt_rd = cnt[2];
            3'd3:    cnt_rd = cnt[3];
            3'd4:    cnt_rd = cnt[4];
            default: cnt_rd = 5'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and decoded controls. pop and out_valid decode straight
    // from the state register so an asynchronous reset clears them at once.
    always_comb begin
        next_state = state;
        pop        = 4'b0000;
        out_valid  = 1'b0;
        start      = 1'b0;
        capture    = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                // empty is only looked at here; later changes are ignored
                if (enable && rr_found) begin
                    start      = 1'b1;
                    next_state = POP;
                end
            end
            POP: begin
                pop        = 4'b0001 << sel;
                next_state = CAPT;
            end
            CAPT: begin
                capture    = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath, counters and counter read-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= 2'd0;
            last_port   <= 2'd3;
            out_data    <= 14'd0;
            count_out   <= 5'd0;
            count_valid <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                cnt[k] <= 5'd0;
            end
        end else begin
            if (start) begin
                sel <= rr_port;
            end
            if (capture) begin
                out_data <= {sel, rd_data};
            end
            if (complete) begin
                last_port <= sel;
                // 5-bit counters wrap naturally 31 -> 0
                case (sel)
                    2'd0:    cnt[0] <= cnt[0] + 5'd1;
                    2'd1:    cnt[1] <= cnt[1] + 5'd1;
                    2'd2:    cnt[2] <= cnt[2] + 5'd1;
                    default: cnt[3] <= cnt[3] + 5'd1;
                endcase
                cnt[4] <= cnt[4] + 5'd1;
            end
            // cnt_rd reads the current register value, so a read that
            // coincides with an increment returns the pre-increment count.
            if (req) begin
                count_out   <= cnt_rd;
                count_valid <= (idx <= 3'd4);
            end else begin
                count_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
